rr_arb_4to16: RTL

//  - Round-robin arbiter sharing one 16-way decoded resource (e.g. a bus or select line) among 16 requesters.
//  - Registers a 4-bit grant index and drives a one-hot 16-bit grant from that index.
//  - Holds each grant until its requester releases.
//  - Sits between the requesting blocks and the 4-to-16 select path; it is the sole driver of that path.

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/rr_arb_4to16_onehot.sv | 9 +
 rtl/rr_arb_4to16.sv | 66 ++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants and rotate-priority pick for the 16-way round-robin arbiter
package rr_arb_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam int TMO_DEF = 255;
  // Descending scan so the lowest offset from p overwrites last and wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] k;
    rr_pick = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = p + IDX_W'(i);
      if (r[k]) rr_pick = k;
    end
  endfunction
endpackage

// File: rtl/rr_arb_4to16_onehot.sv
// grant_onehot_4to16: combinational 4-bit index + enable to 16-bit one-hot
// Ports: idx (binary index), en (zero output when low), onehot (decoded select)
module grant_onehot_4to16 import rr_arb_pkg::*; (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);
  assign onehot = en ? {{(N_REQ-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/rr_arb_4to16.sv
// rr_arb_4to16: round-robin arbiter driving a registered one-hot 16-way grant
// Ports: clk, rst (async active-high), en (gates new grants), req[15:0],
//        gnt[15:0] (one-hot), gnt_idx[3:0], busy (== |gnt), tmo (revocation pulse)
// Optional: define ARB_TIMEOUT_EN to revoke grants held for TMO cycles (TMO parameter, 2..255).
module rr_arb_4to16 import rr_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(parameter int TMO = TMO_DEF)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             tmo
);
  logic st, st_n, tmo_hit;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n;
  logic [N_REQ-1:0] gnt_n;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo_hit = st == ST_GRANT && req[gnt_idx] && cnt == 8'(TMO - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      cnt <= st == ST_IDLE ? '0 : cnt + 8'd1;
      tmo <= tmo_hit;
    end
`else
  assign tmo_hit = 1'b0;
  assign tmo = 1'b0;
`endif
  // Release and forced revocation share one exit path; the pointer always moves past the holder.
  always_comb begin
    st_n = st;
    idx_n = gnt_idx;
    ptr_n = ptr;
    if (st == ST_IDLE) begin
      if (en && |req) begin
        st_n = ST_GRANT;
        idx_n = rr_pick(req, ptr);
      end
    end else if (!req[gnt_idx] || tmo_hit) begin
      st_n = ST_IDLE;
      ptr_n = gnt_idx + 1'b1;
    end
  end
  grant_onehot_4to16 u_onehot (.idx(idx_n), .en(st_n), .onehot(gnt_n));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ST_IDLE;
      gnt_idx <= '0;
      ptr <= '0;
      gnt <= '0;
    end else begin
      st <= st_n;
      gnt_idx <= idx_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
    end
  assign busy = |gnt;
endmodule
